fir_tap_sequencer: RTL and testbench



---
 rtl/fir_pkg.sv | 13 +
 rtl/fir_ptr_ctr.sv | 20 ++
 rtl/fir_tap_sequencer.sv | 103 ++++++++++
 tb/tb_fir_tap_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR tap sequencer.
package fir_pkg;

  localparam int ADDR_W = 4;
  localparam int NTAPS  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fir_ptr_ctr.sv
// Modulo-2**W pointer register with synchronous clear and increment.
// Serves as both the circular write pointer and the tap counter.
module fir_ptr_ctr #(
  parameter int W = fir_pkg::ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Wrap is natural modulo: NTAPS is tied to 2**W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= q + W'(1);
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: accepts a sample, bumps the circular write pointer, then walks all taps for the MAC.
// Optional build macro FIR_SEQ_MAC_STALL_EN adds mac_ready back-pressure from the MAC.
module fir_tap_sequencer #(
  parameter int ADDR_W = fir_pkg::ADDR_W,
  parameter int NTAPS  = fir_pkg::NTAPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] coef_addr,
  output logic              mac_valid,
  output logic              mac_first,
  output logic              mac_last,
`ifdef FIR_SEQ_MAC_STALL_EN
  input  logic              mac_ready,
`endif
  output logic              done,
  output logic              busy
);
  import fir_pkg::*;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] newest;
  logic              accept;
  logic              adv;
  logic              last_tap;

  assign in_ready = (state == IDLE);
  // clr outranks a simultaneous sample so nothing is written on a flush cycle.
  assign accept   = in_valid & in_ready & ~clr;
  assign wr_en    = accept;
  assign last_tap = (k == ADDR_W'(NTAPS - 1));

`ifdef FIR_SEQ_MAC_STALL_EN
  assign adv = mac_ready;
`else
  assign adv = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (adv && last_tap) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clr) state_nx = IDLE;
  end

  fir_ptr_ctr #(.W(ADDR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (accept),
    .q   (wr_ptr)
  );

  // Restarted on every accept so an aborted run can never leak a stale tap index.
  fir_ptr_ctr #(.W(ADDR_W)) u_tap_ctr (
    .clk (clk),
    .rst (rst),
    .clr (clr | accept),
    .inc ((state == RUN) & adv),
    .q   (k)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         newest <= '0;
    else if (accept) newest <= wr_ptr;
  end

  // MAC-side outputs decode purely from registers, so rst/clr zero them without glitching on inputs.
  always_comb begin
    mac_valid = 1'b0;
    mac_first = 1'b0;
    mac_last  = 1'b0;
    rd_addr   = '0;
    coef_addr = '0;
    if (state == RUN) begin
      mac_valid = 1'b1;
      mac_first = (k == '0);
      mac_last  = last_tap;
      coef_addr = k;
      rd_addr   = newest - k;
    end
  end

  assign done = (state == DONE);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Scoreboard bench for fir_tap_sequencer: the driver queues expected wr/mac/done events with cycle stamps,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_fir_tap_sequencer;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid;
  logic       in_ready, wr_en, mac_valid, mac_first, mac_last, done, busy;
  logic [3:0] wr_ptr, rd_addr, coef_addr;
`ifdef FIR_SEQ_MAC_STALL_EN
  logic       mac_ready;
`endif

  fir_tap_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .wr_ptr    (wr_ptr),
    .wr_en     (wr_en),
    .rd_addr   (rd_addr),
    .coef_addr (coef_addr),
    .mac_valid (mac_valid),
    .mac_first (mac_first),
    .mac_last  (mac_last),
`ifdef FIR_SEQ_MAC_STALL_EN
    .mac_ready (mac_ready),
`endif
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;   // 0 write, 1 mac tap, 2 done
    logic [3:0]  a;      // wr_ptr or rd_addr
    logic [3:0]  b;      // coef_addr
    logic        first;
    logic        last;
    logic [31:0] cyc;
  } ev_t;

  ev_t         exp_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] cyc = 0;
  logic [3:0]  mptr = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_ev(input ev_t act, input string name);
    ev_t e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s unexpected event: got %h, expected none", name, act);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        fails++;
        $display("FAIL %s: got %h, expected %h", name, act, e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en)     chk_ev({2'd0, wr_ptr, 4'd0, 1'b0, 1'b0, cyc}, "wr");
      if (mac_valid) chk_ev({2'd1, rd_addr, coef_addr, mac_first, mac_last, cyc}, "mac");
      else begin
        tests++;
        if (rd_addr !== 4'd0 || coef_addr !== 4'd0) begin
          fails++;
          $display("FAIL idle_addr: got rd=%0d coef=%0d, expected 0/0", rd_addr, coef_addr);
        end
      end
      if (done)      chk_ev({2'd2, 4'd0, 4'd0, 1'b0, 1'b0, cyc}, "done");
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at posedge+2; returns once in_ready is seen, or flags a timeout.
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
    tests++;
    if (!in_ready) begin
      fails++;
      $display("FAIL ready_timeout: got in_ready=0, expected 1 within 40 cycles");
    end
  endtask

  // Offer one sample and queue the expected response: ntap taps, optional done,
  // tap stall_at presented stall_n extra cycles.
  task automatic issue(input int ntap, input bit with_done, input bit hold,
                       input int stall_at, input int stall_n, output logic [31:0] c);
    ev_t        e;
    logic [3:0] kk;
    int         ex;
    wait_ready();
    c = cyc;
    e = '{kind: 2'd0, a: mptr, b: 4'd0, first: 1'b0, last: 1'b0, cyc: c};
    exp_q.push_back(e);
    for (int k = 0; k < ntap; k++) begin
      kk = 4'(k);
      ex = (k > stall_at) ? stall_n : 0;
      for (int r = 0; r <= ((k == stall_at) ? stall_n : 0); r++) begin
        e = '{kind: 2'd1, a: mptr - kk, b: kk, first: (k == 0), last: (k == 15),
              cyc: c + 1 + 32'(k) + 32'(ex) + 32'(r)};
        exp_q.push_back(e);
      end
    end
    if (with_done) begin
      e = '{kind: 2'd2, a: 4'd0, b: 4'd0, first: 1'b0, last: 1'b0, cyc: c + 17 + 32'(stall_n)};
      exp_q.push_back(e);
    end
    in_valid = 1'b1;
    mptr = mptr + 4'd1;
    @(posedge clk); #2;
    if (!hold) in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] c;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0;
`ifdef FIR_SEQ_MAC_STALL_EN
    mac_ready = 1'b1;
`endif
    @(posedge clk); #2;
    chk("rst_wr_ptr", 32'(wr_ptr), 0);
    chk("rst_strobes", {27'd0, mac_valid, mac_first, mac_last, done, busy}, 0);
    chk("rst_addr", {24'd0, rd_addr, coef_addr}, 0);
    rst = 1'b0;
    #1 chk("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #2;

    // 18 back-to-back samples: ptr 0..15, wrap to 0, then 1 (covers newest=13 and newest=0 cases)
    for (int i = 0; i < 18; i++) issue(16, 1'b1, 1'b0, 99, 0, c);
    wait_ready();
    chk("wrap_wr_ptr", 32'(wr_ptr), 2);

    // clr while tap 7 is on the bus: taps 0..7 only, no done
    issue(8, 1'b0, 1'b0, 99, 0, c);
    repeat (7) begin @(posedge clk); #2; end
    clr = 1'b1;
    @(posedge clk); #2;
    clr = 1'b0;
    mptr = 4'd0;
    chk("clr_mac_valid", 32'(mac_valid), 0);
    chk("clr_wr_ptr", 32'(wr_ptr), 0);
    chk("clr_busy", 32'(busy), 0);
    repeat (3) begin @(posedge clk); #2; end

    // clr and in_valid together in IDLE: no write
    clr = 1'b1; in_valid = 1'b1;
    #1 chk("clr_vs_valid_wr_en", 32'(wr_en), 0);
    @(posedge clk); #2;
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_vs_valid_ptr", 32'(wr_ptr), 0);
    chk("clr_vs_valid_busy", 32'(busy), 0);
    issue(16, 1'b1, 1'b0, 99, 0, c);

    // async rst after tap 4 with in_valid held high through RUN
    issue(5, 1'b0, 1'b1, 99, 0, c);
    repeat (4) begin @(posedge clk); #2; end
    @(negedge clk); #2;
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("arst_mac_valid", 32'(mac_valid), 0);
    chk("arst_wr_ptr", 32'(wr_ptr), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_addr", {24'd0, rd_addr, coef_addr}, 0);
    mptr = 4'd0;
    @(posedge clk); #2;
    rst = 1'b0;
    issue(16, 1'b1, 1'b0, 99, 0, c);

`ifdef FIR_SEQ_MAC_STALL_EN
    // mac_ready low for 3 cycles while tap 4 is presented
    issue(16, 1'b1, 1'b0, 4, 3, c);
    repeat (4) begin @(posedge clk); #2; end
    mac_ready = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    mac_ready = 1'b1;
`endif

    wait_ready();
    repeat (2) begin @(posedge clk); #2; end
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
